// File: rtl/cpu_dbg_pkg.sv
// rtl/cpu_dbg_pkg.sv - shared opcodes and scheduler state encodings
// Opcode values are shared with cpu_com_controller.
package cpu_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_STEP     = 3'd1,
    ST_RUN_N    = 3'd2,
    ST_RUN_FREE = 3'd3,
    ST_BP_HALT  = 3'd4
  } sched_state_t;

  typedef enum logic [2:0] {
    CMD_NOP      = 3'd0,
    CMD_HALT     = 3'd1,
    CMD_STEP     = 3'd2,
    CMD_RUN_N    = 3'd3,
    CMD_RUN_FREE = 3'd4,
    CMD_SET_BP   = 3'd5,
    CMD_CLR_BP   = 3'd6,
    CMD_RSVD     = 3'd7
  } sched_cmd_t;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_STEP     = 3'd1;
  localparam logic [2:0] S_RUN_N    = 3'd2;
  localparam logic [2:0] S_RUN_FREE = 3'd3;
  localparam logic [2:0] S_BP_HALT  = 3'd4;

  localparam logic [2:0] OP_NOP      = 3'd0;
  localparam logic [2:0] OP_HALT     = 3'd1;
  localparam logic [2:0] OP_STEP     = 3'd2;
  localparam logic [2:0] OP_RUN_N    = 3'd3;
  localparam logic [2:0] OP_RUN_FREE = 3'd4;
  localparam logic [2:0] OP_SET_BP   = 3'd5;
  localparam logic [2:0] OP_CLR_BP   = 3'd6;

  function automatic logic is_run_op(input logic [2:0] op);
    return (op == OP_STEP) || (op == OP_RUN_N) || (op == OP_RUN_FREE);
  endfunction

endpackage

// File: rtl/cpu_exec_scheduler_if.sv
// rtl/cpu_exec_scheduler_if.sv - command handshake from the communication controller
interface cpu_exec_scheduler_if #(
  parameter int PC_W = 32
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [2:0]      cmd_op;
  logic [PC_W-1:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/cpu_exec_scheduler_tick_prescaler.sv
// rtl/cpu_exec_scheduler_tick_prescaler.sv - modulo-PRESCALE counter with wrap pulse
module tick_prescaler #(
  parameter int PRESCALE = 163
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic wrap
);
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap  = en && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en)
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end
endmodule

// File: rtl/cpu_exec_scheduler.sv
// rtl/cpu_exec_scheduler.sv - CPU cycle sequencer: step, run-N, free-run, breakpoint
module cpu_exec_scheduler
  import cpu_dbg_pkg::*;
#(
  parameter int PRESCALE = 163,
  parameter int CNT_W    = 16,
  parameter int PC_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  cpu_exec_scheduler_if.slave  cmd,
  input  logic [PC_W-1:0]      pc,
  output logic                 cpu_tick,
  output logic                 busy,
  output logic                 bp_hit,
  output logic [2:0]           state,
  output logic [CNT_W-1:0]     cycles_done
);
  logic [2:0]       state_q, state_d;
  logic             cpu_tick_q, cpu_tick_d;
  logic             busy_q, busy_d;
  logic             bp_hit_q, bp_hit_d;
  logic             bp_en_q, bp_en_d;
  logic             first_tick_q, first_tick_d;
  logic [PC_W-1:0]  bp_addr_q, bp_addr_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  logic busy_state, accept, halt_acc, tick_point;

  assign busy_state    = (state_q == S_STEP) || (state_q == S_RUN_N) || (state_q == S_RUN_FREE);
  assign cmd.cmd_ready = !busy_state || !is_run_op(cmd.cmd_op);
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign halt_acc      = accept && (cmd.cmd_op == OP_HALT);

  // Held cleared whenever not running, so every run starts from a fresh count.
  tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (!busy_state),
    .en    (busy_state),
    .wrap  (tick_point)
  );

  always_comb begin
    state_d      = state_q;
    cpu_tick_d   = 1'b0;
    bp_hit_d     = bp_hit_q;
    bp_en_d      = bp_en_q;
    bp_addr_d    = bp_addr_q;
    first_tick_d = first_tick_q;
    cycles_d     = cycles_q;
    remaining_d  = remaining_q;

    if (accept) begin
      case (cmd.cmd_op)
        OP_HALT: begin
          state_d  = S_IDLE;
          bp_hit_d = 1'b0;
        end
        OP_SET_BP: begin
          bp_addr_d = cmd.cmd_arg;
          bp_en_d   = 1'b1;
        end
        OP_CLR_BP: bp_en_d = 1'b0;
        OP_STEP, OP_RUN_N, OP_RUN_FREE: begin
          cycles_d     = '0;
          bp_hit_d     = 1'b0;
          first_tick_d = 1'b1;
          if (cmd.cmd_op == OP_STEP)
            state_d = S_STEP;
          else if (cmd.cmd_op == OP_RUN_FREE)
            state_d = S_RUN_FREE;
          else begin
            remaining_d = cmd.cmd_arg[CNT_W-1:0];
            state_d     = (cmd.cmd_arg[CNT_W-1:0] == '0) ? S_IDLE : S_RUN_N;
          end
        end
        default: ;
      endcase
    end

    // A coincident HALT suppresses the tick point entirely.
    if (tick_point && !halt_acc) begin
      if (bp_en_q && (pc == bp_addr_q) && !first_tick_q) begin
        state_d  = S_BP_HALT;
        bp_hit_d = 1'b1;
      end else begin
        cpu_tick_d   = 1'b1;
        first_tick_d = 1'b0;
        cycles_d     = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
        if (state_q == S_STEP)
          state_d = S_IDLE;
        else if (state_q == S_RUN_N) begin
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1))
            state_d = S_IDLE;
        end
      end
    end

    busy_d = (state_d == S_STEP) || (state_d == S_RUN_N) || (state_d == S_RUN_FREE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cpu_tick_q   <= 1'b0;
      busy_q       <= 1'b0;
      bp_hit_q     <= 1'b0;
      bp_en_q      <= 1'b0;
      bp_addr_q    <= '0;
      first_tick_q <= 1'b0;
      cycles_q     <= '0;
      remaining_q  <= '0;
    end else begin
      state_q      <= state_d;
      cpu_tick_q   <= cpu_tick_d;
      busy_q       <= busy_d;
      bp_hit_q     <= bp_hit_d;
      bp_en_q      <= bp_en_d;
      bp_addr_q    <= bp_addr_d;
      first_tick_q <= first_tick_d;
      cycles_q     <= cycles_d;
      remaining_q  <= remaining_d;
    end
  end

  assign cpu_tick    = cpu_tick_q;
  assign busy        = busy_q;
  assign bp_hit      = bp_hit_q;
  assign state       = state_q;
  assign cycles_done = cycles_q;
endmodule

// File: tb/tb_cpu_exec_scheduler.sv
// tb/tb_cpu_exec_scheduler.sv - directed self-checking bench for cpu_exec_scheduler
module tb_cpu_exec_scheduler;
  import cpu_dbg_pkg::*;

  localparam int PRESCALE = 4;
  localparam int CNT_W    = 16;
  localparam int PC_W     = 32;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [PC_W-1:0]  pc;
  logic             cpu_tick, busy, bp_hit;
  logic [2:0]       state;
  logic [CNT_W-1:0] cycles_done;

  int checks = 0;
  int failures = 0;
  int nt, first_at, last_at;

  cpu_exec_scheduler_if #(.PC_W(PC_W)) cmd_if ();

  cpu_exec_scheduler #(.PRESCALE(PRESCALE), .CNT_W(CNT_W), .PC_W(PC_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd         (cmd_if),
    .pc          (pc),
    .cpu_tick    (cpu_tick),
    .busy        (busy),
    .bp_hit      (bp_hit),
    .state       (state),
    .cycles_done (cycles_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] arg);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_arg   = arg;
    adv();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cmd_arg   = '0;
  endtask

  task automatic watch(input int n);
    nt = 0;
    first_at = 0;
    last_at = 0;
    for (int i = 1; i <= n; i++) begin
      adv();
      if (cpu_tick === 1'b1) begin
        nt++;
        if (first_at == 0) first_at = i;
        last_at = i;
      end
    end
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cmd_arg   = '0;
    pc               = '0;
    #12;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_tick", 32'(cpu_tick), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_bp_hit", 32'(bp_hit), 32'd0);
    chk("rst_cycles", 32'(cycles_done), 32'd0);
    adv();
    reset = 1'b1;
    adv();

    // single step
    cmd_if.cmd_op = OP_STEP;
    #1;
    chk("idle_ready_step", 32'(cmd_if.cmd_ready), 32'd1);
    issue(OP_STEP, 32'd0);
    chk("step_state", 32'(state), 32'd1);
    chk("step_busy", 32'(busy), 32'd1);
    watch(10);
    chk("step_nticks", 32'(nt), 32'd1);
    chk("step_latency", 32'(first_at), 32'd4);
    chk("step_end_state", 32'(state), 32'd0);
    chk("step_cycles", 32'(cycles_done), 32'd1);

    // run 5
    issue(OP_RUN_N, 32'd5);
    chk("run5_cycles_clr", 32'(cycles_done), 32'd0);
    watch(25);
    chk("run5_nticks", 32'(nt), 32'd5);
    chk("run5_first", 32'(first_at), 32'd4);
    chk("run5_last", 32'(last_at), 32'd20);
    chk("run5_busy", 32'(busy), 32'd0);
    chk("run5_cycles", 32'(cycles_done), 32'd5);

    // run 0
    issue(OP_RUN_N, 32'd0);
    chk("run0_state", 32'(state), 32'd0);
    chk("run0_busy", 32'(busy), 32'd0);
    watch(8);
    chk("run0_nticks", 32'(nt), 32'd0);

    // free run, HALT exactly on the second tick point
    issue(OP_RUN_FREE, 32'd0);
    chk("free_state", 32'(state), 32'd3);
    watch(7);
    chk("free_nticks", 32'(nt), 32'd1);
    cmd_if.cmd_op = OP_HALT;
    #1;
    chk("busy_ready_halt", 32'(cmd_if.cmd_ready), 32'd1);
    issue(OP_HALT, 32'd0);
    chk("halt_tick_supp", 32'(cpu_tick), 32'd0);
    chk("halt_state", 32'(state), 32'd0);
    chk("halt_cycles", 32'(cycles_done), 32'd1);
    watch(8);
    chk("halt_no_ticks", 32'(nt), 32'd0);
    cmd_if.cmd_op = OP_STEP;
    #1;
    chk("halt_ready_step", 32'(cmd_if.cmd_ready), 32'd1);
    cmd_if.cmd_op = OP_NOP;

    // breakpoint at 0x10 after three ticks
    issue(OP_SET_BP, 32'h10);
    chk("setbp_state", 32'(state), 32'd0);
    issue(OP_RUN_FREE, 32'd0);
    watch(12);
    chk("bp_pre_ticks", 32'(nt), 32'd3);
    pc = 32'h10;
    watch(8);
    chk("bp_no_tick", 32'(nt), 32'd0);
    chk("bp_state", 32'(state), 32'd4);
    chk("bp_hit", 32'(bp_hit), 32'd1);
    chk("bp_busy", 32'(busy), 32'd0);
    chk("bp_cycles", 32'(cycles_done), 32'd3);
    issue(OP_STEP, 32'd0);
    chk("bp_step_clr_hit", 32'(bp_hit), 32'd0);
    watch(8);
    chk("bp_step_ticks", 32'(nt), 32'd1);
    chk("bp_step_state", 32'(state), 32'd0);

    // commands offered while busy
    pc = 32'h0;
    issue(OP_RUN_FREE, 32'd0);
    cmd_if.cmd_op = OP_STEP;
    #1;
    chk("busy_ready_step", 32'(cmd_if.cmd_ready), 32'd0);
    cmd_if.cmd_op = OP_RUN_N;
    #1;
    chk("busy_ready_runn", 32'(cmd_if.cmd_ready), 32'd0);
    cmd_if.cmd_op = OP_RUN_FREE;
    #1;
    chk("busy_ready_free", 32'(cmd_if.cmd_ready), 32'd0);
    cmd_if.cmd_op = OP_SET_BP;
    #1;
    chk("busy_ready_setbp", 32'(cmd_if.cmd_ready), 32'd1);
    issue(OP_SET_BP, 32'h20);
    pc = 32'h20;
    watch(10);
    chk("busy_setbp_ticks", 32'(nt), 32'd1);
    chk("busy_setbp_state", 32'(state), 32'd4);
    chk("busy_setbp_hit", 32'(bp_hit), 32'd1);
    issue(OP_RUN_FREE, 32'd0);
    cmd_if.cmd_op = OP_CLR_BP;
    #1;
    chk("busy_ready_clrbp", 32'(cmd_if.cmd_ready), 32'd1);
    issue(OP_CLR_BP, 32'd0);
    watch(10);
    chk("clrbp_ticks", 32'(nt), 32'd2);
    chk("clrbp_state", 32'(state), 32'd3);
    chk("clrbp_hit", 32'(bp_hit), 32'd0);
    issue(OP_HALT, 32'd0);
    chk("halt2_state", 32'(state), 32'd0);

    // async reset in the middle of a long run
    issue(OP_RUN_N, 32'd100);
    watch(4);
    chk("mid_tick_high", 32'(cpu_tick), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_tick", 32'(cpu_tick), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_bp_hit", 32'(bp_hit), 32'd0);
    chk("arst_cycles", 32'(cycles_done), 32'd0);
    adv();
    adv();
    reset = 1'b1;
    adv();
    issue(OP_STEP, 32'd0);
    watch(8);
    chk("post_rst_ticks", 32'(nt), 32'd1);
    chk("post_rst_latency", 32'(first_at), 32'd4);
    chk("post_rst_cycles", 32'(cycles_done), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cpu_exec_scheduler.md
Name: cpu_exec_scheduler

Overview:
- Sequences CPU execution by issuing single-clk `cpu_tick` enable pulses that advance the CPU and data memory by one cycle each.
- Supports halt, single-step, run-N, free-run and a single PC breakpoint; commands come from the communication controller over a valid/ready handshake.
- Sits between `cpu_com_controller` and the `cpu_run` net; replaces the fixed clock divider as the CPU cycle source.

Parameters:
- PRESCALE, 163, clk cycles per CPU tick (>=1); 1 = tick every clk while running.
- CNT_W, 16, width of run count and `cycles_done`.
- PC_W, 32, PC and breakpoint address width.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command acceptable this cycle
- cmd_op  input  3  0 NOP, 1 HALT, 2 STEP, 3 RUN_N, 4 RUN_FREE, 5 SET_BP, 6 CLR_BP, 7 reserved (treated as NOP)
- cmd_arg  input  PC_W  N for RUN_N (low CNT_W bits); address for SET_BP
- pc  input  PC_W  current CPU PC
- cpu_tick  output  1  one-clk pulse = one CPU cycle
- busy  output  1  high in STEP/RUN_N/RUN_FREE
- bp_hit  output  1  sticky; set on breakpoint stop
- state  output  3  encoded FSM state for debug LEDs
- cycles_done  output  CNT_W  ticks issued since last accepted run command; saturates at all-ones

Behaviour:
- Reset (async assert, sync release): state=IDLE, cpu_tick=0, busy=0, bp_hit=0, cycles_done=0, bp_en=0, bp_addr=0, prescaler=0, remaining=0.
- States (encoding): IDLE=0, STEP=1, RUN_N=2, RUN_FREE=3, BP_HALT=4.
- Acceptance = cmd_valid & cmd_ready.
  - `cmd_ready` = 1 when state is IDLE or BP_HALT.
  - `cmd_ready` = 1 in any state when cmd_op is NOP, HALT, SET_BP or CLR_BP.
  - `cmd_ready` = 0 for STEP, RUN_N or RUN_FREE while busy.
  - `cmd_ready` is combinational from cmd_op and state.
- Run command accepted (STEP/RUN_N/RUN_FREE):
  - Next clk: enter that state; prescaler=0; cycles_done=0; bp_hit=0; first_tick flag=1.
  - RUN_N: remaining = cmd_arg[CNT_W-1:0].
  - RUN_N with N=0: go directly to IDLE with no tick.
- Tick generation while busy:
  - Prescaler counts 0..PRESCALE-1; a tick point occurs when prescaler==PRESCALE-1, then prescaler wraps to 0.
  - First tick therefore fires PRESCALE clks after entry.
- Breakpoint check at each tick point:
  - If bp_en & pc==bp_addr & first_tick==0: no tick; state=BP_HALT; bp_hit=1.
  - first_tick exempts the first tick so execution can resume from a breakpoint PC.
- Otherwise a tick point drives cpu_tick=1 for one clk; first_tick=0; cycles_done++ (saturating).
  - STEP: go to IDLE after its tick.
  - RUN_N: decrement remaining; go to IDLE after the tick that brings remaining to 0.
  - RUN_FREE: continue until HALT or breakpoint.
- HALT accepted: next state=IDLE and the tick in that cycle is suppressed (HALT wins over a coincident tick point). In IDLE or BP_HALT, HALT moves to IDLE and clears bp_hit.
- SET_BP: bp_addr=cmd_arg, bp_en=1; takes effect from the next tick point, in any state.
- CLR_BP: bp_en=0; bp_hit is unchanged.
- busy and state are registered; cpu_tick is registered (asserted the clk after the tick point is decided).
- Async reset mid-run: ticks stop immediately; all state is cleared as above.

Decomposition:
- Shared package `cpu_dbg_pkg`:
  - enum `sched_state_t` (5 states, 3-bit).
  - enum `sched_cmd_t` (3-bit opcodes above).
  - localparams for the opcode values, shared with `cpu_com_controller`.
- One sub-module, `tick_prescaler`: PRESCALE counter with clear and enable inputs and a wrap-pulse output.
- FSM, breakpoint comparator and counters live in the top of the block.

Test Plan:
- PRESCALE=4; reset; STEP -> exactly one cpu_tick, 4 clks after acceptance; state returns to 0; cycles_done=1.
- RUN_N arg=5 -> 5 ticks spaced 4 clks apart; busy drops after the 5th tick; cycles_done=5. RUN_N arg=0 -> no tick, IDLE next clk.
- RUN_FREE, then HALT on the exact cycle of a tick point -> that tick is suppressed; IDLE; cmd_ready=1 for STEP.
- SET_BP 0x10; RUN_FREE; drive pc=0x10 after 3 ticks -> no 4th tick; state=4; bp_hit=1. Then STEP with pc still 0x10 -> 1 tick; bp_hit cleared.
- RUN_FREE busy; STEP/RUN_N offered -> cmd_ready=0; SET_BP and CLR_BP offered -> cmd_ready=1 and take effect.
- Assert reset mid RUN_N arg=100 -> cpu_tick=0 immediately; all outputs at reset values; the block accepts STEP after release.
